// File: rtl/posit_check_pkg.sv
// Shared types and helpers for the posit multiplier result checker (N=32, es=2).
package posit_check_pkg;

    localparam int unsigned POSIT_N = 32;

    localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
    localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;

    typedef struct packed {
        logic [POSIT_N-1:0] in1;
        logic [POSIT_N-1:0] in2;
        logic [POSIT_N-1:0] exp;
    } chk_entry_t;

    localparam int unsigned ENTRY_W = $bits(chk_entry_t);

    // Unsigned distance between two raw bit patterns.
    function automatic logic [POSIT_N-1:0] abs_diff(input logic [POSIT_N-1:0] a,
                                                    input logic [POSIT_N-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/posit_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; callers must not push when full or pop when empty.
module posit_sync_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem[rptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/posit_mult_result_checker.sv
// In-order scoreboard pairing multiplier results with golden products captured at issue.
module posit_mult_result_checker
    import posit_check_pkg::*;
#(
    parameter int unsigned N     = POSIT_N,
    parameter int unsigned ES    = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned TOL   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [N-1:0]             issue_in1,
    input  logic [N-1:0]             issue_in2,
    input  logic [N-1:0]             issue_exp,
    input  logic                     res_valid,
    input  logic [N-1:0]             res_result,
    input  logic                     res_inf,
    input  logic                     res_zero,
    output logic                     mm_valid,
    output logic [N-1:0]             mm_in1,
    output logic [N-1:0]             mm_in2,
    output logic [N-1:0]             mm_result,
    output logic [N-1:0]             mm_exp,
    output logic [N-1:0]             mm_diff,
    output logic                     mm_flag_err,
    output logic [CNT_W-1:0]         checked_cnt,
    output logic [CNT_W-1:0]         error_cnt,
    output logic [N-1:0]             max_diff,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow,
    output logic                     underflow
);

    if (N != POSIT_N || ES >= N) begin : g_bad_cfg
        $error("posit_mult_result_checker: N must equal POSIT_N and ES must be below N");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("posit_mult_result_checker: DEPTH must be a power of two");
    end

    chk_entry_t wr_entry, head;
    logic [ENTRY_W-1:0] head_bits;
    logic full, empty, push, pop;
    logic [N-1:0] diff;
    logic flag_bad, fail;

    // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
    assign pop  = res_valid & ~empty;
    assign push = issue_valid & (~full | pop);

    assign wr_entry = '{in1: issue_in1, in2: issue_in2, exp: issue_exp};

    posit_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head_bits),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    assign head     = chk_entry_t'(head_bits);
    assign diff     = abs_diff(head.exp, res_result);
    assign flag_bad = (res_inf != (res_result == POSIT_NAR)) |
                      (res_zero != (res_result == POSIT_ZERO));
    assign fail     = (diff > N'(TOL)) | flag_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            mm_valid    <= 1'b0;
            mm_in1      <= '0;
            mm_in2      <= '0;
            mm_result   <= '0;
            mm_exp      <= '0;
            mm_diff     <= '0;
            mm_flag_err <= 1'b0;
            checked_cnt <= '0;
            error_cnt   <= '0;
            max_diff    <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            mm_valid <= pop & fail;
            if (issue_valid & full & ~pop) overflow  <= 1'b1;
            if (res_valid & empty)         underflow <= 1'b1;
            if (pop) begin
                if (checked_cnt != '1) checked_cnt <= checked_cnt + 1'b1;
                if (diff > max_diff)   max_diff    <= diff;
                if (fail) begin
                    if (error_cnt != '1) error_cnt <= error_cnt + 1'b1;
                    mm_in1      <= head.in1;
                    mm_in2      <= head.in2;
                    mm_result   <= res_result;
                    mm_exp      <= head.exp;
                    mm_diff     <= diff;
                    mm_flag_err <= flag_bad;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_mult_result_checker.sv
// Directed self-checking bench for posit_mult_result_checker.
module tb_posit_mult_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [31:0] issue_in1, issue_in2, issue_exp;
    logic        res_valid;
    logic [31:0] res_result;
    logic        res_inf, res_zero;
    logic        mm_valid;
    logic [31:0] mm_in1, mm_in2, mm_result, mm_exp, mm_diff;
    logic        mm_flag_err;
    logic [31:0] checked_cnt, error_cnt, max_diff;
    logic [3:0]  pending;
    logic        overflow, underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    posit_mult_result_checker dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_in1   (issue_in1),
        .issue_in2   (issue_in2),
        .issue_exp   (issue_exp),
        .res_valid   (res_valid),
        .res_result  (res_result),
        .res_inf     (res_inf),
        .res_zero    (res_zero),
        .mm_valid    (mm_valid),
        .mm_in1      (mm_in1),
        .mm_in2      (mm_in2),
        .mm_result   (mm_result),
        .mm_exp      (mm_exp),
        .mm_diff     (mm_diff),
        .mm_flag_err (mm_flag_err),
        .checked_cnt (checked_cnt),
        .error_cnt   (error_cnt),
        .max_diff    (max_diff),
        .pending     (pending),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_in1   = '0;
        issue_in2   = '0;
        issue_exp   = '0;
        res_valid   = 1'b0;
        res_result  = '0;
        res_inf     = 1'b0;
        res_zero    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        idle();
        issue_valid = 1'b1;
        issue_in1   = a;
        issue_in2   = b;
        issue_exp   = e;
        tick();
        idle();
    endtask

    task automatic result(input logic [31:0] r, input logic inf, input logic zero);
        idle();
        res_valid  = 1'b1;
        res_result = r;
        res_inf    = inf;
        res_zero   = zero;
        tick();
        idle();
    endtask

    // Issue one pair, then deliver its result four cycles later.
    task automatic pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                        input logic [31:0] r, input logic inf, input logic zero);
        issue(a, b, e);
        tick();
        tick();
        tick();
        result(r, inf, zero);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mm_valid, mm_flag_err, overflow, underflow} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {mm_valid, mm_flag_err, overflow, underflow});
        end
        checks++;
        if (checked_cnt !== 32'd0 || error_cnt !== 32'd0 || max_diff !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", checked_cnt, error_cnt, max_diff);
        end
        checks++;
        if (pending !== 4'd0) begin
            failures++;
            $display("FAIL reset_pending got=%0d want=0", pending);
        end
    endtask

    task automatic test_pass();
        pair(32'h4000_0000, 32'h4800_0000, 32'h4800_0000, 32'h4800_0000, 1'b0, 1'b0);
        checks++;
        if (mm_valid !== 1'b0 || checked_cnt !== 32'd1 || error_cnt !== 32'd0) begin
            failures++;
            $display("FAIL pass got mm_valid=%b checked=%0d errors=%0d want 0/1/0",
                     mm_valid, checked_cnt, error_cnt);
        end
    endtask

    task automatic test_mismatch();
        pair(32'h4000_0000, 32'h4800_0000, 32'h4800_0000, 32'h4800_0001, 1'b0, 1'b0);
        checks++;
        if (mm_valid !== 1'b1 || mm_diff !== 32'd1 || error_cnt !== 32'd1 || max_diff !== 32'd1) begin
            failures++;
            $display("FAIL mismatch1 got v=%b diff=%0d err=%0d max=%0d want 1/1/1/1",
                     mm_valid, mm_diff, error_cnt, max_diff);
        end
        checks++;
        if (mm_in1 !== 32'h4000_0000 || mm_in2 !== 32'h4800_0000 || mm_exp !== 32'h4800_0000 ||
            mm_result !== 32'h4800_0001 || mm_flag_err !== 1'b0) begin
            failures++;
            $display("FAIL mismatch1_data got %h %h %h %h fe=%b want 40000000 48000000 48000000 48000001 0",
                     mm_in1, mm_in2, mm_exp, mm_result, mm_flag_err);
        end
        tick();
        checks++;
        if (mm_valid !== 1'b0 || mm_diff !== 32'd1) begin
            failures++;
            $display("FAIL mismatch_pulse got v=%b diff=%0d want 0/1", mm_valid, mm_diff);
        end
        pair(32'h4000_0000, 32'h4800_0000, 32'h4800_0000, 32'h47FF_FFFE, 1'b0, 1'b0);
        checks++;
        if (mm_valid !== 1'b1 || mm_diff !== 32'd2 || max_diff !== 32'd2 || error_cnt !== 32'd2 ||
            checked_cnt !== 32'd3) begin
            failures++;
            $display("FAIL mismatch2 got v=%b diff=%0d max=%0d err=%0d chk=%0d want 1/2/2/2/3",
                     mm_valid, mm_diff, max_diff, error_cnt, checked_cnt);
        end
    endtask

    task automatic test_flag_err();
        pair(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        checks++;
        if (mm_valid !== 1'b1 || mm_flag_err !== 1'b1 || mm_diff !== 32'd0 || error_cnt !== 32'd3 ||
            max_diff !== 32'd2) begin
            failures++;
            $display("FAIL flag_err got v=%b fe=%b diff=%0d err=%0d max=%0d want 1/1/0/3/2",
                     mm_valid, mm_flag_err, mm_diff, error_cnt, max_diff);
        end
        pair(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        checks++;
        if (mm_valid !== 1'b0 || error_cnt !== 32'd3 || checked_cnt !== 32'd5) begin
            failures++;
            $display("FAIL flag_ok got v=%b err=%0d chk=%0d want 0/3/5", mm_valid, error_cnt, checked_cnt);
        end
        pair(32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        checks++;
        if (mm_valid !== 1'b1 || mm_flag_err !== 1'b1 || error_cnt !== 32'd4) begin
            failures++;
            $display("FAIL zero_flag got v=%b fe=%b err=%0d want 1/1/4", mm_valid, mm_flag_err, error_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exps [1000];
        int pend_bad = 0;
        do_reset();
        for (int i = 0; i < 1000; i++) exps[i] = $urandom;
        exps[10] = 32'h8000_0000;
        exps[20] = 32'h0000_0000;
        for (int t = 0; t < 1004; t++) begin
            idle();
            if (t < 1000) begin
                issue_valid = 1'b1;
                issue_in1   = $urandom;
                issue_in2   = $urandom;
                issue_exp   = exps[t];
            end
            if (t >= 4) begin
                res_valid  = 1'b1;
                res_result = exps[t-4];
                res_inf    = (exps[t-4] == 32'h8000_0000);
                res_zero   = (exps[t-4] == 32'h0000_0000);
            end
            tick();
            if (t >= 3 && t < 1000 && pending !== 4'd4) pend_bad++;
        end
        idle();
        checks++;
        if (pend_bad !== 0) begin
            failures++;
            $display("FAIL stream_pending got bad_cycles=%0d want 0", pend_bad);
        end
        checks++;
        if (checked_cnt !== 32'd1000 || error_cnt !== 32'd0 || pending !== 4'd0) begin
            failures++;
            $display("FAIL stream_counts got chk=%0d err=%0d pend=%0d want 1000/0/0",
                     checked_cnt, error_cnt, pending);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL stream_sticky got ovf=%b unf=%b want 0/0", overflow, underflow);
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        result(32'h4000_0000, 1'b0, 1'b0);
        checks++;
        if (underflow !== 1'b1 || checked_cnt !== 32'd0 || error_cnt !== 32'd0 || mm_valid !== 1'b0) begin
            failures++;
            $display("FAIL underflow got unf=%b chk=%0d err=%0d v=%b want 1/0/0/0",
                     underflow, checked_cnt, error_cnt, mm_valid);
        end
        for (int i = 0; i < 8; i++) issue(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        checks++;
        if (pending !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill got pend=%0d ovf=%b want 8/0", pending, overflow);
        end
        issue(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        checks++;
        if (pending !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow got pend=%0d ovf=%b want 8/1", pending, overflow);
        end
        idle();
        issue_valid = 1'b1;
        issue_in1   = 32'h4000_0000;
        issue_in2   = 32'h4000_0000;
        issue_exp   = 32'h4000_0000;
        res_valid   = 1'b1;
        res_result  = 32'h4000_0000;
        tick();
        idle();
        checks++;
        if (pending !== 4'd8 || checked_cnt !== 32'd1 || error_cnt !== 32'd0) begin
            failures++;
            $display("FAIL full_push_pop got pend=%0d chk=%0d err=%0d want 8/1/0",
                     pending, checked_cnt, error_cnt);
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        pair(32'h1111_1111, 32'h2222_2222, 32'h4800_0000, 32'h4800_0001, 1'b0, 1'b0);
        issue(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        issue(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        issue(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        checks++;
        if (pending !== 4'd3 || mm_in1 !== 32'h1111_1111) begin
            failures++;
            $display("FAIL pre_reset got pend=%0d in1=%h want 3/11111111", pending, mm_in1);
        end
        do_reset();
        checks++;
        if (pending !== 4'd0 || checked_cnt !== 32'd0 || error_cnt !== 32'd0 || max_diff !== 32'd0 ||
            mm_in1 !== 32'd0 || mm_in2 !== 32'd0 || mm_exp !== 32'd0 || mm_result !== 32'd0 ||
            mm_diff !== 32'd0 || mm_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got pend=%0d chk=%0d err=%0d max=%0d in1=%h in2=%h exp=%h res=%h diff=%0d v=%b want all 0",
                     pending, checked_cnt, error_cnt, max_diff, mm_in1, mm_in2, mm_exp, mm_result,
                     mm_diff, mm_valid);
        end
        pair(32'h4000_0000, 32'h4800_0000, 32'h4800_0000, 32'h4800_0000, 1'b0, 1'b0);
        checks++;
        if (mm_valid !== 1'b0 || checked_cnt !== 32'd1 || error_cnt !== 32'd0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got v=%b chk=%0d err=%0d unf=%b want 0/1/0/0",
                     mm_valid, checked_cnt, error_cnt, underflow);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_pass();
        test_mismatch();
        test_flag_err();
        test_back_to_back();
        test_boundaries();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
